// File: rtl/frequency_generator_if.sv
// Request/response bundle of the frequency generator: BCD edge request,
// window length update, and the generated square wave with its status flags.
`timescale 1ns/1ps
interface frequency_generator_if #(
  parameter int BITS = 12
);
  logic [3:0]      tens_count;
  logic [3:0]      unit_count;
  logic            load;
  logic [BITS-1:0] period;
  logic            period_load;
  logic            signal;
  logic            window_start;
  logic            busy;

  modport master (
    output tens_count, unit_count, load, period, period_load,
    input  signal, window_start, busy
  );

  modport slave (
    input  tens_count, unit_count, load, period, period_load,
    output signal, window_start, busy
  );
endinterface

// File: rtl/frequency_generator.sv
// Frequency generator: produces a square wave with a BCD-programmed number of
// rising edges per window of (update_period + 1) clocks. Edges are spread with
// a first-order accumulator; the BCD request is converted by repeated addition.
`timescale 1ns/1ps
module frequency_generator #(
  parameter int UPDATE_PERIOD = 1200,
  parameter int BITS          = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  frequency_generator_if.slave bus
);

  localparam int SUM_W = BITS + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      tens_r;
  logic [6:0]      edges;
  logic [BITS-1:0] acc;
  logic [BITS-1:0] win_cnt;
  logic [BITS-1:0] update_period;
  logic            sig_r;
  logic            ws_r;
  logic            busy_r;

  logic [SUM_W-1:0] edges_x2;
  logic [SUM_W-1:0] limit;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] excess;
  logic             saturate;
  logic             overflow;
  logic             wrap;

  // BCD digits above 9 are read as 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Accumulator arithmetic: each cycle adds 2*edges against a modulus of window length.
  always_comb begin
    edges_x2 = SUM_W'({edges, 1'b0});
    limit    = {1'b0, update_period} + SUM_W'(1);
    sum      = {1'b0, acc} + edges_x2;
    excess   = sum - limit;
    saturate = (edges_x2 >= limit);
    overflow = (sum >= limit);
    wrap     = (win_cnt == update_period);
  end

  // Control FSM with registered outputs; load overrides everything but reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tens_r        <= 4'd0;
      edges         <= 7'd0;
      acc           <= '0;
      win_cnt       <= '0;
      update_period <= BITS'(UPDATE_PERIOD);
      sig_r         <= 1'b0;
      ws_r          <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      if (bus.period_load)
        update_period <= bus.period;

      if (bus.load) begin
        tens_r <= clamp_bcd(bus.tens_count);
        edges  <= {3'b000, clamp_bcd(bus.unit_count)};
        state  <= CONVERT;
        busy_r <= 1'b1;
        sig_r  <= 1'b0;
        ws_r   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sig_r  <= 1'b0;
            ws_r   <= 1'b0;
            busy_r <= 1'b0;
          end

          CONVERT: begin
            if (tens_r == 4'd0) begin
              // First RUN cycle opens a window with a clean accumulator.
              state   <= RUN;
              win_cnt <= '0;
              acc     <= '0;
              busy_r  <= 1'b0;
              ws_r    <= 1'b1;
              sig_r   <= 1'b0;
            end else begin
              edges  <= edges + 7'd10;
              tens_r <= tens_r - 4'd1;
            end
          end

          RUN: begin
            if (bus.period_load) begin
              // New window length: restart the window from scratch.
              acc     <= '0;
              win_cnt <= '0;
              sig_r   <= 1'b0;
              ws_r    <= 1'b1;
            end else begin
              win_cnt <= wrap ? '0 : win_cnt + 1'b1;
              ws_r    <= wrap;
              if (saturate) begin
                sig_r <= ~sig_r;
                acc   <= '0;
              end else if (overflow) begin
                sig_r <= ~sig_r;
                acc   <= excess[BITS-1:0];
              end else begin
                acc   <= sum[BITS-1:0];
              end
            end
          end

          default: begin
            state  <= IDLE;
            sig_r  <= 1'b0;
            ws_r   <= 1'b0;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.signal       = sig_r;
  assign bus.window_start = ws_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_frequency_generator.sv
// Bench for frequency_generator: closed-form reference of the expected wave
// (toggle count = floor(2*edges*t / window)) plus per-window edge counting.
`timescale 1ns/1ps
module tb_frequency_generator;

  localparam int UPDATE_PERIOD = 1200;
  localparam int BITS          = 12;

  logic clk = 1'b0;
  logic reset;

  frequency_generator_if #(.BITS(BITS)) ifc ();

  frequency_generator #(
    .UPDATE_PERIOD(UPDATE_PERIOD),
    .BITS         (BITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 converting, 2 running.
  int m_mode = 0;
  int m_conv = 0;
  int m_e    = 0;
  int m_n    = UPDATE_PERIOD + 1;
  int m_t    = 0;

  // Window bookkeeping on the observed wave.
  bit cnt_valid = 1'b0;
  bit prev_sig  = 1'b0;
  int rise_cnt  = 0;
  int win_len   = 0;
  int win_done  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp9(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic step();
    bit exp_sig, exp_ws, exp_busy, sat;
    int t, new_n;
    @(posedge clk);
    if (reset) begin
      m_mode    = 0;
      m_e       = 0;
      m_n       = UPDATE_PERIOD + 1;
      cnt_valid = 1'b0;
    end else begin
      new_n = m_n;
      if (ifc.period_load) new_n = int'(ifc.period) + 1;
      if (ifc.load) begin
        m_mode    = 1;
        m_e       = 10 * clamp9(int'(ifc.tens_count)) + clamp9(int'(ifc.unit_count));
        m_conv    = clamp9(int'(ifc.tens_count)) + 1;
        cnt_valid = 1'b0;
      end else if (m_mode == 1) begin
        m_conv--;
        if (m_conv == 0) begin
          m_mode    = 2;
          m_t       = 0;
          cnt_valid = 1'b0;
        end
      end else if (m_mode == 2) begin
        if (ifc.period_load) begin
          m_t       = 0;
          cnt_valid = 1'b0;
        end else begin
          m_t++;
        end
      end
      m_n = new_n;
    end

    @(negedge clk);
    sat      = (2 * m_e >= m_n);
    exp_busy = (m_mode == 1);
    exp_ws   = 1'b0;
    exp_sig  = 1'b0;
    if (m_mode == 2) begin
      t      = m_t % m_n;
      exp_ws = (t == 0);
      if (sat) exp_sig = ((m_t % 2) == 1);
      else     exp_sig = ((((2 * m_e * t) / m_n) % 2) == 1);
    end
    check_eq("signal",       32'(ifc.signal),       32'(exp_sig));
    check_eq("window_start", 32'(ifc.window_start), 32'(exp_ws));
    check_eq("busy",         32'(ifc.busy),         32'(exp_busy));

    if (ifc.window_start) begin
      if (cnt_valid) begin
        if (!(sat && (m_n % 2 == 1)))
          check_eq("rises_per_window", rise_cnt, sat ? m_n / 2 : m_e);
        check_eq("window_length", win_len, m_n);
        win_done++;
      end
      rise_cnt  = 0;
      win_len   = 0;
      cnt_valid = 1'b1;
    end
    win_len++;
    if (ifc.signal && !prev_sig) rise_cnt++;
    prev_sig = ifc.signal;

    ifc.load        = 1'b0;
    ifc.period_load = 1'b0;
  endtask

  task automatic do_load(input int tens, input int units);
    ifc.tens_count = 4'(tens);
    ifc.unit_count = 4'(units);
    ifc.load       = 1'b1;
    step();
  endtask

  task automatic do_period(input int p);
    ifc.period      = BITS'(p);
    ifc.period_load = 1'b1;
    step();
  endtask

  task automatic run_windows(input int n, input string tag);
    int start;
    int budget;
    start  = win_done;
    budget = (n + 2) * m_n + 200;
    while ((win_done - start) < n && budget > 0) begin
      step();
      budget--;
    end
    check_eq(tag, win_done - start, n);
  endtask

  initial begin
    int op, len;
    reset           = 1'b1;
    ifc.tens_count  = 4'd0;
    ifc.unit_count  = 4'd0;
    ifc.load        = 1'b0;
    ifc.period      = '0;
    ifc.period_load = 1'b0;

    repeat (3) step();
    reset = 1'b0;
    repeat (5000) step();

    do_load(4, 2);
    run_windows(3, "windows_42");

    do_load(12, 15);
    run_windows(3, "windows_99");

    do_load(0, 0);
    run_windows(2, "windows_0");

    do_period(9);
    do_load(0, 7);
    run_windows(5, "windows_sat");

    do_period(1199);
    do_load(2, 5);
    repeat (700) step();
    do_period(199);
    run_windows(3, "windows_200");

    do_period(1199);
    do_load(4, 2);
    repeat (600) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (1500) step();
    do_load(0, 3);
    run_windows(1, "windows_after_reset");

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        do_load($urandom_range(0, 15), $urandom_range(0, 15));
      end else if (op <= 5) begin
        do_period($urandom_range(9, 300));
      end else if (op == 6) begin
        ifc.period      = BITS'($urandom_range(9, 300));
        ifc.period_load = 1'b1;
        do_load($urandom_range(0, 15), $urandom_range(0, 15));
      end else if (op == 7) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 400);
      repeat (len) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
